instr_fetch_fsm: RTL

- Instruction-fetch sequencer and instruction register (IR) for the 16-bit microcontroller datapath.
- Fetches the word at PC over the shared bus/MAR/MDR path and latches it into IR.
- Presents IR as the instruction word to the execute FSMs (load/store, ALU ops, ...) and gates them with IF_active.
- Waits for the executing FSM's done pulse, then starts the next fetch.

---
 rtl/instr_fetch_fsm.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_fsm.sv
// Instruction-fetch sequencer and instruction register for the 16-bit datapath.
// Walks PC -> MAR -> memory -> MDR -> IR, then hands IR to the execute FSMs
// (IF_active low) until exec_done or an execute timeout returns it to fetch.
// Optional build macro IF_MFC_TIMEOUT_EN adds an abort of a stalled memory
// read after MFC_TIMEOUT cycles without MFC.
module instr_fetch_fsm #(
  parameter int unsigned EXEC_TIMEOUT = 32,
  parameter int unsigned MFC_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MFC,
  input  logic        exec_done,
  input  logic [15:0] bus_in,
  output logic        PC_out,
  output logic        MAR_EN,
  output logic        mem_EN,
  output logic        mem_RW,
  output logic        MDR_EN_read,
  output logic        MDR_out,
  output logic        PC_inc,
  output logic        IF_active,
  output logic [15:0] instr,
  output logic        bad_instr
);

  localparam int unsigned TW = 8;
  localparam int unsigned IW = 16;

  typedef enum logic [2:0] {
    S_RST,
    S_PCOUT,
    S_MEMRD,
    S_MDRLD,
    S_IRLD,
    S_EXEC
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] exec_timer;
  logic          bad_c;

  logic pc_out_nx;
  logic mar_en_nx;
  logic mem_en_nx;
  logic mem_rw_nx;
  logic mdr_en_read_nx;
  logic mdr_out_nx;
  logic pc_inc_nx;
  logic if_active_nx;

  // Elaboration-time range guard on the timeout parameters
  if (EXEC_TIMEOUT < 2 || EXEC_TIMEOUT > 255) begin : g_exec_range
    $error("EXEC_TIMEOUT must be in 2..255");
  end
  if (MFC_TIMEOUT < 2 || MFC_TIMEOUT > 255) begin : g_mfc_range
    $error("MFC_TIMEOUT must be in 2..255");
  end

`ifdef IF_MFC_TIMEOUT_EN
  logic [TW-1:0] mfc_timer;

  // Counts S_MEMRD cycles spent waiting for MFC; zero outside S_MEMRD
  always_ff @(posedge clk) begin
    if (rst) begin
      mfc_timer <= '0;
    end else if (state == S_MEMRD) begin
      mfc_timer <= mfc_timer + TW'(1);
    end else begin
      mfc_timer <= '0;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RST;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and timeout detection
  always_comb begin
    next_state = state;
    bad_c      = 1'b0;
    case (state)
      S_RST:   next_state = S_PCOUT;
      S_PCOUT: next_state = S_MEMRD;
      S_MEMRD: begin
        if (MFC) begin
          next_state = S_MDRLD;
        end
`ifdef IF_MFC_TIMEOUT_EN
        else if (mfc_timer == TW'(MFC_TIMEOUT - 1)) begin
          next_state = S_PCOUT;
          bad_c      = 1'b1;
        end
`endif
      end
      S_MDRLD: next_state = S_IRLD;
      S_IRLD:  next_state = S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          next_state = S_PCOUT;
        end else if (exec_timer == TW'(EXEC_TIMEOUT - 1)) begin
          next_state = S_PCOUT;
          bad_c      = 1'b1;
        end
      end
      default: next_state = S_RST;
    endcase
  end

  // Control decode of the upcoming state, so the registered outputs track state
  always_comb begin
    pc_out_nx      = 1'b0;
    mar_en_nx      = 1'b0;
    mem_en_nx      = 1'b0;
    mem_rw_nx      = 1'b0;
    mdr_en_read_nx = 1'b0;
    mdr_out_nx     = 1'b0;
    pc_inc_nx      = 1'b0;
    if_active_nx   = 1'b1;
    case (next_state)
      S_PCOUT: begin
        pc_out_nx = 1'b1;
        mar_en_nx = 1'b1;
      end
      S_MEMRD: begin
        mem_en_nx = 1'b1;
        mem_rw_nx = 1'b1;
      end
      S_MDRLD: begin
        mem_en_nx      = 1'b1;
        mem_rw_nx      = 1'b1;
        mdr_en_read_nx = 1'b1;
      end
      S_IRLD: begin
        mdr_out_nx = 1'b1;
        pc_inc_nx  = 1'b1;
      end
      S_EXEC:  if_active_nx = 1'b0;
      default: ;
    endcase
  end

  // Registered control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      PC_out      <= 1'b0;
      MAR_EN      <= 1'b0;
      mem_EN      <= 1'b0;
      mem_RW      <= 1'b0;
      MDR_EN_read <= 1'b0;
      MDR_out     <= 1'b0;
      PC_inc      <= 1'b0;
      IF_active   <= 1'b1;
    end else begin
      PC_out      <= pc_out_nx;
      MAR_EN      <= mar_en_nx;
      mem_EN      <= mem_en_nx;
      mem_RW      <= mem_rw_nx;
      MDR_EN_read <= mdr_en_read_nx;
      MDR_out     <= mdr_out_nx;
      PC_inc      <= pc_inc_nx;
      IF_active   <= if_active_nx;
    end
  end

  // Execute-phase timer: zero on S_EXEC entry, counts each S_EXEC cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      exec_timer <= '0;
    end else if (state == S_EXEC) begin
      exec_timer <= exec_timer + TW'(1);
    end else begin
      exec_timer <= '0;
    end
  end

  // Instruction register, loaded from the bus at the end of S_IRLD
  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= IW'(0);
    end else if (state == S_IRLD) begin
      instr <= bus_in;
    end
  end

  // One-cycle abandon pulse following a timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_instr <= 1'b0;
    end else begin
      bad_instr <= bad_c;
    end
  end

endmodule
